// File: rtl/lfsr_seq_checker_pkg.sv
// Shared LFSR checker definitions: default width/taps and FSM state encoding.
// No logic; imported by lfsr_step and lfsr_seq_checker.
package lfsr_seq_checker_pkg;

    localparam int          LFSR_WIDTH = 8;
    localparam logic [31:0] LFSR_TAPS  = 32'h0000_00B8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step LFSR advance; dir=0 steps up, dir=1 steps back (exact inverse).
// Zero latency, no flow control.
module lfsr_step
    import lfsr_seq_checker_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS[WIDTH-1:0]
) (
    input  logic             dir,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        if (!dir) begin
            nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
        end else begin
            // Feedback bit is recovered from the MSB tap, which must always be set.
            nxt = {cur[0] ^ (^(cur[WIDTH-1:1] & TAPS[WIDTH-2:0])), cur[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Locks onto an up/down LFSR count stream and counts mispredictions; optional LFSR_CHK_PERIOD_EN period check.
// Outputs registered one clk after the sampling edge; enable=0 freezes all state.
module lfsr_seq_checker
    import lfsr_seq_checker_pkg::*;
#(
    parameter int               WIDTH    = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS[WIDTH-1:0],
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] count,
    input  logic             overflow,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             zero_err,
    output logic [ERR_W-1:0] wraps
`ifdef LFSR_CHK_PERIOD_EN
    ,
    output logic             period_err
`endif
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);

    chk_state_t       state, state_nxt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] exp_val;
    logic             prev_vld, prev_vld_nxt;
    logic [MW-1:0]    match, match_nxt;
    logic [LW-1:0]    miss_run, miss_nxt;
    logic             hit;
    logic             miss_evt;

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
        .dir (up_down),
        .cur (prev),
        .nxt (exp_val)
    );

    // An all-zero count is the LFSR lockup state and never a legal step.
    assign hit    = (count == exp_val) && (count != '0);
    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        match_nxt    = match;
        miss_nxt     = miss_run;
        prev_vld_nxt = prev_vld;
        miss_evt     = 1'b0;
        if (enable) begin
            prev_vld_nxt = 1'b1;
            if (prev_vld) begin
                case (state)
                    SEARCH: begin
                        if (!hit) begin
                            match_nxt = '0;
                        end else if (match == MATCH_LAST) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                        end else begin
                            match_nxt = match + MW'(1);
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            miss_nxt = '0;
                        end else begin
                            miss_evt = 1'b1;
                            if (miss_run == MISS_LAST) begin
                                state_nxt    = SEARCH;
                                miss_nxt     = '0;
                                match_nxt    = '0;
                                prev_vld_nxt = 1'b0;
                            end else begin
                                miss_nxt = miss_run + LW'(1);
                            end
                        end
                    end
                    default: state_nxt = SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev      <= '0;
            prev_vld  <= 1'b0;
            match     <= '0;
            miss_run  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            zero_err  <= 1'b0;
            wraps     <= '0;
        end else begin
            prev_vld  <= prev_vld_nxt;
            match     <= match_nxt;
            miss_run  <= miss_nxt;
            err_pulse <= miss_evt;
            if (enable) begin
                prev <= count;
            end
            if (clr_err) begin
                err_count <= '0;
            end else if (miss_evt && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (clr_err) begin
                zero_err <= 1'b0;
            end else if (enable && (count == '0)) begin
                zero_err <= 1'b1;
            end
            if (enable && overflow && (state == LOCKED)) begin
                wraps <= wraps + ERR_W'(1);
            end
        end
    end

`ifdef LFSR_CHK_PERIOD_EN
    // Samples strictly between two overflow pulses; a maximal sequence leaves 2^WIDTH-2 of them.
    localparam logic [WIDTH:0] PERIOD_GAP = {1'b0, {WIDTH{1'b1}}} - (WIDTH+1)'(1);

    logic [WIDTH:0] period_cnt;
    logic           period_armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt   <= '0;
            period_armed <= 1'b0;
            period_err   <= 1'b0;
        end else begin
            if (state != LOCKED) begin
                period_cnt   <= '0;
                period_armed <= 1'b0;
            end else if (enable) begin
                if (overflow) begin
                    period_cnt   <= '0;
                    period_armed <= 1'b1;
                end else begin
                    period_cnt <= period_cnt + (WIDTH+1)'(1);
                end
            end
            if (clr_err) begin
                period_err <= 1'b0;
            end else if ((state == LOCKED) && enable && overflow && period_armed
                         && (period_cnt != PERIOD_GAP)) begin
                period_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed self-checking bench for lfsr_seq_checker (8-bit, taps 8'hB8).
// Inputs change 1 time unit after the rising edge; outputs checked there too.
module tb_lfsr_seq_checker;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        up_down;
    logic [7:0]  count;
    logic        overflow;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        zero_err;
    logic [15:0] wraps;
`ifdef LFSR_CHK_PERIOD_EN
    logic        period_err;
`endif

    int checks = 0;
    int errors = 0;
    int pulses;
    logic [7:0] cur;

    lfsr_seq_checker dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .up_down   (up_down),
        .count     (count),
        .overflow  (overflow),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .zero_err  (zero_err),
        .wraps     (wraps)
`ifdef LFSR_CHK_PERIOD_EN
        ,
        .period_err(period_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] up8(input logic [7:0] c);
        return {c[6:0], ^(c & 8'hB8)};
    endfunction

    // Backward step found by search so it does not share a formula with the design.
    function automatic logic [7:0] dn8(input logic [7:0] c);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            if (up8(v) == c) return v;
        end
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [7:0] c, input logic ud, input logic ov);
        count    = c;
        up_down  = ud;
        overflow = ov;
        enable   = 1'b1;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        overflow = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; up_down = 1'b0; count = 8'h00;
        overflow = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_errcnt", {16'd0, err_count}, 32'd0);
        chk("rst_zero", {31'd0, zero_err}, 32'd0);
        chk("rst_wraps", {16'd0, wraps}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Acquire: load + 4 hits
        cur = 8'h01;
        sample(cur, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cur = up8(cur);
            sample(cur, 1'b0, 1'b0);
            if (i == 3) chk("lock_after4", {31'd0, locked}, 32'd0);
        end
        chk("lock_after5", {31'd0, locked}, 32'd1);
        for (int i = 5; i < 20; i++) begin
            cur = up8(cur);
            sample(cur, 1'b0, 1'b0);
        end
        chk("lock_errcnt", {16'd0, err_count}, 32'd0);
        chk("lock_held", {31'd0, locked}, 32'd1);

        // 10 up then 10 down, overflow pulses on two steps
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 10) begin
                cur = up8(cur);
                sample(cur, 1'b0, (i == 5));
            end else begin
                cur = dn8(cur);
                sample(cur, 1'b1, (i == 15));
            end
            pulses += int'(err_pulse);
        end
        chk("dir_pulses", pulses, 32'd0);
        chk("dir_locked", {31'd0, locked}, 32'd1);
        chk("dir_wraps", {16'd0, wraps}, 32'd2);

        // Overflow with enable low is ignored
        overflow = 1'b1;
        @(posedge clk);
        #1;
        overflow = 1'b0;
        chk("hold_wraps", {16'd0, wraps}, 32'd2);
        chk("hold_pulse", {31'd0, err_pulse}, 32'd0);

        // Single corrupt sample: two mispredictions, lock kept
        cur = up8(cur);
        sample(cur ^ 8'h01, 1'b0, 1'b0);
        chk("corr1_pulse", {31'd0, err_pulse}, 32'd1);
        chk("corr1_cnt", {16'd0, err_count}, 32'd1);
        cur = up8(cur);
        sample(cur, 1'b0, 1'b0);
        chk("corr2_cnt", {16'd0, err_count}, 32'd2);
        chk("corr2_locked", {31'd0, locked}, 32'd1);
        cur = up8(cur);
        sample(cur, 1'b0, 1'b0);
        chk("corr3_pulse", {31'd0, err_pulse}, 32'd0);
        chk("corr3_cnt", {16'd0, err_count}, 32'd2);

        // Three consecutive corrupt samples drop lock
        for (int i = 0; i < 3; i++) begin
            cur = up8(cur);
            sample(cur ^ 8'h01, 1'b0, 1'b0);
            if (i == 1) chk("loss_after2", {31'd0, locked}, 32'd1);
        end
        chk("loss_after3", {31'd0, locked}, 32'd0);
        chk("loss_cnt", {16'd0, err_count}, 32'd5);

        // Relock: load + 4 hits
        for (int i = 0; i < 5; i++) begin
            cur = up8(cur);
            sample(cur, 1'b0, 1'b0);
            if (i == 3) chk("relock_after4", {31'd0, locked}, 32'd0);
        end
        chk("relock_after5", {31'd0, locked}, 32'd1);
        chk("relock_cnt", {16'd0, err_count}, 32'd5);

        // All-zero count: sticky zero_err, treated as miss
        sample(8'h00, 1'b0, 1'b0);
        chk("zero_flag", {31'd0, zero_err}, 32'd1);
        chk("zero_pulse", {31'd0, err_pulse}, 32'd1);
        cur = up8(cur);
        sample(cur, 1'b0, 1'b0);
        chk("zero_next_cnt", {16'd0, err_count}, 32'd7);
        cur = up8(cur);
        sample(cur, 1'b0, 1'b0);
        chk("zero_recov_pulse", {31'd0, err_pulse}, 32'd0);
        chk("zero_sticky", {31'd0, zero_err}, 32'd1);
        chk("zero_locked", {31'd0, locked}, 32'd1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_zero", {31'd0, zero_err}, 32'd0);
        chk("clr_cnt", {16'd0, err_count}, 32'd0);

        // Clear and miss on the same sample: clear wins
        cur = up8(cur);
        clr_err = 1'b1;
        sample(cur ^ 8'h01, 1'b0, 1'b0);
        clr_err = 1'b0;
        chk("clrmiss_pulse", {31'd0, err_pulse}, 32'd1);
        chk("clrmiss_cnt", {16'd0, err_count}, 32'd0);
        cur = up8(cur);
        sample(cur, 1'b0, 1'b0);
        chk("clrmiss_next", {16'd0, err_count}, 32'd1);
        cur = up8(cur);
        sample(cur, 1'b0, 1'b0);
        chk("clrmiss_locked", {31'd0, locked}, 32'd1);

        // Async reset between edges
        #3;
        reset = 1'b0;
        #1;
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_cnt", {16'd0, err_count}, 32'd0);
        chk("arst_wraps", {16'd0, wraps}, 32'd0);

`ifdef LFSR_CHK_PERIOD_EN
        @(posedge clk);
        #1;
        reset = 1'b1;
        cur = 8'h01;
        sample(cur, 1'b0, 1'b0);
        for (int k = 1; k <= 510; k++) begin
            cur = up8(cur);
            sample(cur, 1'b0, (cur == 8'h01));
        end
        chk("per_wraps", {16'd0, wraps}, 32'd2);
        chk("per_err", {31'd0, period_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
